booth_mult_seq: RTL
===================

# booth_mult_seq

Sequential radix-4 Booth multiplier that produces the signed product stream consumed by the saturating multiply-accumulator. It takes two signed DW-bit operands per start request and returns a sign-extended 2*DW+2-bit product on `res_t` for exactly one cycle, flagged by `done`. Outside that cycle `res_t` is held at zero, so the downstream accumulator, which adds `res_t` every cycle, adds each product exactly once.

## Interface
- `DW`, default 32: operand width in bits. Must be even and ≥ 4.
- `clk`  in  1: single clock, rising edge.
- `n_rst`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  DW: multiplicand, two's complement; sampled with `start`.
- `b`  in  DW: multiplier, two's complement; sampled with `start`.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse; `res_t` is valid in this cycle.
- `res_t`  out  2*DW+2: product. Bits [2*DW-1:0] hold the 2*DW-bit signed product; bits [2*DW+1:2*DW] copy bit 2*DW-1. Zero whenever `done`=0.

## Operation
- Three states: IDLE, CALC, DONE. Reset forces IDLE. `busy`, `done` and `res_t` all reset to 0, and all internal registers clear.
- IDLE: when `start`=1 at an edge, latch `a` into the multiplicand register (sign-extended to DW+2). Load the accumulator as {(DW+2) zeros, `b`, 1'b0}. Load the digit counter with DW/2. Go to CALC.
- CALC: each cycle processes one Booth digit taken from the 3 LSBs of the {multiplier, guard} field:
  - 000 and 111: +0
  - 001 and 010: +A
  - 011: +2A
  - 100: −2A
  - 101 and 110: −A
- After the add, arithmetic-shift the whole accumulator right by 2. Decrement the counter. When the counter reaches 1 on an edge, the digit processed on that edge is the last one; go to DONE.
- DONE: drive `res_t` with the registered product, sign-extended to 2*DW+2, and set `done`=1. Return to IDLE on the next edge, where `res_t` goes back to 0 and `done` to 0.
- The upper partial-product field is DW+2 bits, so ±2A never overflows. Every signed product fits in 2*DW bits, including (−2^(DW−1))² = 2^(2DW−2). No saturation in this block.
- `start` is ignored in CALC and DONE. There is no queueing; a dropped request is lost and `busy` tells the source to wait.
- `a` and `b` are don't-care except on the edge where `start` is accepted.
- Reset mid-operation: the operation is aborted immediately and asynchronously. `res_t` and `done` go to 0 and no partial product is ever emitted.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
- CALC occupies edges E1..E(DW/2). DONE is entered at E(DW/2).
- `done`=1 and `res_t` are valid from E(DW/2) to E(DW/2+1): 16 cycles after E0 for DW=32.
- `busy` rises right after E0 and falls at E(DW/2+1).
- Earliest next accept is E(DW/2+2). Maximum throughput is one product per DW/2+2 cycles (18 for DW=32).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- 3 × 5, DW=32 → `done` pulses once, 16 cycles after E0, with `res_t`=0x0_0000_0000_0000_000F; `res_t`=0 in every other cycle.
- −7 × 6 (a=0xFFFF_FFF9, b=6) → `res_t`=0x3_FFFF_FFFF_FFFF_FFD6, i.e. bits [65:64]=11.
- 0x8000_0000 × 0x8000_0000 → `res_t`=0x0_4000_0000_0000_0000. Then 0x7FFF_FFFF × 0x8000_0000 → `res_t`=0x3_C000_0000_8000_0000.
- Pulse `start` again with new operands at E3 and in the DONE cycle → both requests ignored, the first result is unchanged, and `busy` stays high through DONE. A request at E(DW/2+2) is accepted.
- Assert `n_rst` low at E8 of an operation → `busy`, `done` and `res_t` are 0 immediately. After release, no `done` occurs until a new `start`, and a fresh 2 × 2 returns 4.
- Random signed operands, 1000 back-to-back requests (`start` held high) → each `res_t` matches the reference a*b. `done` pulses are spaced exactly 18 cycles apart, and the running sum of `res_t` equals the sum of the products.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one signed DW x DW product per DW/2+2 cycles.
// res_t carries the sign-extended product only during the single done cycle and is zero otherwise.
module booth_mult_seq #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DW-1:0]     a,
    input  logic [DW-1:0]     b,
    output logic              busy,
    output logic              done,
    output logic [2*DW+1:0]   res_t,
    output logic [1:0]        dbg_state
);

    // Handshake: start is accepted only on an edge where busy is low (IDLE);
    // requests while busy are dropped. done is a one-cycle pulse and res_t is
    // valid only in that cycle, zero in every other cycle.

    localparam int AW = 2*DW + 3;
    localparam int CW = $clog2(DW/2 + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [DW+1:0]   mcand, mcand_next;
    logic [AW-1:0]   acc, acc_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [DW+1:0]   pp;
    logic [DW+1:0]   upper_sum;
    logic [2*DW-1:0] prod_next;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // acc layout: {upper partial product (DW+2), multiplier (DW), guard bit}
    always_comb begin
        state_next = state;
        mcand_next = mcand;
        acc_next   = acc;
        cnt_next   = cnt;
        pp         = '0;
        upper_sum  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    mcand_next = {{2{a[DW-1]}}, a};
                    acc_next   = {{(DW+2){1'b0}}, b, 1'b0};
                    cnt_next   = CW'(DW/2);
                    state_next = CALC;
                end
            end
            CALC: begin
                case (acc[2:0])
                    3'b001, 3'b010: pp = mcand;
                    3'b011:         pp = mcand << 1;
                    3'b100:         pp = -(mcand << 1);
                    3'b101, 3'b110: pp = -mcand;
                    default:        pp = '0;
                endcase
                upper_sum = acc[AW-1:DW+1] + pp;
                acc_next  = AW'($signed({upper_sum, acc[DW:0]}) >>> 2);
                cnt_next  = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // After DW/2 double shifts the original upper field has moved down by DW bits.
        prod_next = acc_next[2*DW:1];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            res_t <= '0;
        end else begin
            mcand <= mcand_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            res_t <= (state_next == DONE) ? {{2{prod_next[2*DW-1]}}, prod_next} : '0;
        end
    end

endmodule
